// File: rtl/zx_video_fetch_if.sv
// Video-page read port between the fetch stage (master) and the video RAM (slave).
// The RAM is synchronous: it samples vram_addr/vram_rd on one edge and the
// fetch stage captures vram_q on the following edge.
interface zx_video_fetch_if;
    logic [12:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_q;

    modport master (
        output vram_addr,
        output vram_rd,
        input  vram_q
    );

    modport slave (
        input  vram_addr,
        input  vram_rd,
        output vram_q
    );
endinterface

// File: rtl/zx_video_fetch.sv
// ZX pixel/attribute fetch and colour stage.
// Fetches one bitmap byte and one attribute byte per 8-pixel group, serialises
// the bitmap MSB first and emits {bright,G,R,B} eight clocks after the timing
// generator sample that produced each pixel. Border colour is emitted outside
// the active window.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a phase-0 sample inside the active window
// RD_PIX   | group latched; drive bitmap address and read strobe
// RD_ATTR  | drive attribute address and read strobe
// CAP_ATTR | capture bitmap byte; attribute byte is captured next edge
module zx_video_fetch #(
    parameter logic [12:0] ATTR_BASE  = 13'h1800,
    parameter int          FLASH_BITS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   busy,
    input  logic [7:0]             h_count,
    input  logic [7:0]             v_count,
    input  logic [2:0]             border,
    zx_video_fetch_if.master       vram,
    output logic [3:0]             pix_color,
    output logic                   pix_active
);

    typedef enum logic [1:0] {
        IDLE,
        RD_PIX,
        RD_ATTR,
        CAP_ATTR
    } state_t;

    state_t                  state;
    logic [4:0]              grp_col;
    logic [7:0]              grp_v;
    logic [7:0]              pix_buf;
    logic [7:0]              attr_buf;
    logic                    attr_cap;
    logic                    grp_start;
    logic [12:0]             pix_addr;
    logic [12:0]             attr_addr;

    logic [7:0]              dl_busy;
    logic [7:0]              dl_start;
    logic [7:0][2:0]         dl_border;

    logic                    busy_q;
    logic [7:0]              v_q;
    logic [FLASH_BITS-1:0]   flash_cnt;
    logic                    flash_phase;
    logic                    frame_end;

    logic [7:0]              shift_reg;
    logic [7:0]              cur_attr;
    logic                    loaded;

    function automatic logic [3:0] colour_of(input logic b, input logic [7:0] a,
                                             input logic ph);
        logic sel;
        sel = b ^ (a[7] & ph);
        return {a[6], sel ? a[2:0] : a[5:3]};
    endfunction

    assign grp_start   = (state == IDLE) && busy && (h_count[2:0] == 3'd0);
    // Bitmap rows are interleaved: third, row-in-char, char-row, column.
    assign pix_addr    = {grp_v[7:6], grp_v[2:0], grp_v[5:3], grp_col};
    assign attr_addr   = ATTR_BASE + {3'b000, grp_v[7:3], grp_col};
    assign flash_phase = flash_cnt[FLASH_BITS-1];
    assign frame_end   = busy_q && !busy && (v_q == 8'd191);

    // Fetch FSM: two reads per group, bitmap then attribute, with registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            grp_col        <= '0;
            grp_v          <= '0;
            vram.vram_addr <= '0;
            vram.vram_rd   <= 1'b0;
            pix_buf        <= '0;
            attr_buf       <= '0;
            attr_cap       <= 1'b0;
        end else begin
            attr_cap <= 1'b0;
            if (attr_cap)
                attr_buf <= vram.vram_q;
            case (state)
                IDLE: begin
                    vram.vram_rd <= 1'b0;
                    if (grp_start) begin
                        grp_col <= h_count[7:3];
                        grp_v   <= v_count;
                        state   <= RD_PIX;
                    end
                end
                RD_PIX: begin
                    vram.vram_addr <= pix_addr;
                    vram.vram_rd   <= 1'b1;
                    state          <= RD_ATTR;
                end
                RD_ATTR: begin
                    vram.vram_addr <= attr_addr;
                    vram.vram_rd   <= 1'b1;
                    state          <= CAP_ATTR;
                end
                CAP_ATTR: begin
                    vram.vram_rd <= 1'b0;
                    pix_buf      <= vram.vram_q;
                    attr_cap     <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Eight-stage delay line aligning window, border and group-start with the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            dl_busy   <= '0;
            dl_start  <= '0;
            dl_border <= '0;
        end else begin
            dl_busy   <= {dl_busy[6:0], busy};
            dl_start  <= {dl_start[6:0], grp_start};
            dl_border <= {dl_border[6:0], border};
        end
    end

    // Frame counter for flash: advances when the window closes after line 191.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b0;
            v_q       <= '0;
            flash_cnt <= '0;
        end else begin
            busy_q <= busy;
            v_q    <= v_count;
            if (frame_end)
                flash_cnt <= flash_cnt + {{(FLASH_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Serialiser and colour output; a delayed group start reloads the shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            cur_attr   <= '0;
            loaded     <= 1'b0;
            pix_color  <= '0;
            pix_active <= 1'b0;
        end else begin
            pix_active <= dl_busy[7];
            if (!dl_busy[7]) begin
                loaded    <= 1'b0;
                pix_color <= {1'b0, dl_border[7]};
            end else if (dl_start[7]) begin
                shift_reg <= {pix_buf[6:0], 1'b0};
                cur_attr  <= attr_buf;
                loaded    <= 1'b1;
                pix_color <= colour_of(pix_buf[7], attr_buf, flash_phase);
            end else if (loaded) begin
                shift_reg <= {shift_reg[6:0], 1'b0};
                pix_color <= colour_of(shift_reg[7], cur_attr, flash_phase);
            end else begin
                // Line entered mid-group: nothing fetched yet, show black.
                pix_color <= 4'h0;
            end
        end
    end

endmodule

// File: doc/zx_video_fetch.md
Name: zx_video_fetch

Overview:
- Pixel/attribute fetch and colour stage directly downstream of the ZX video timing generator.
- Consumes the generator's busy/h_count/v_count, reads bitmap and attribute bytes from the 6912-byte video page, serialises the pixels, and applies ink/paper/bright/flash.
- Emits one 4-bit colour per clock to the video DAC/encoder stage; border colour is emitted outside the active window.

Parameters:
ATTR_BASE, 13'h1800, offset of attribute area within video page
FLASH_BITS, 5, width of frame counter; flash phase = counter MSB (period 2^FLASH_BITS frames, default 32: 16 on/16 off)

Ports:
clk  in  1  system pixel clock (one pixel per clock)
reset  in  1  synchronous, active-high reset
busy  in  1  timing generator: active video window
h_count  in  8  timing generator: pixel column 0..255
v_count  in  8  timing generator: pixel line 0..191
border  in  3  border colour {G,R,B}, sampled every clock
vram_addr  out  13  registered byte offset into video page
vram_rd  out  1  registered read strobe
vram_q  in  8  read data; synchronous RAM, samples addr/rd one edge after they change, data captured by this block the following edge
pix_color  out  4  {bright,G,R,B}, registered
pix_active  out  1  registered; busy delayed by 8 clocks

Behaviour:
- Reset (sync, high): vram_addr=0, vram_rd=0, pix_color=0, pix_active=0; shift reg, pixel/attr buffers, delay line, flash counter cleared. Reset mid-line abandons any fetch; next fetch only at next phase-0 sample after release.
- Phase p = h_count[2:0]. A group starts on edge E0 where busy=1 and p=0; h/v sampled at E0 latched for that group.
- Fetch FSM states: IDLE, RD_PIX, RD_ATTR, CAP_ATTR.
  - IDLE -> RD_PIX at E0: E1 drives vram_addr = {v[7:6],v[2:0],v[5:3],h[7:3]}, vram_rd=1.
  - RD_PIX -> RD_ATTR: E2 drives vram_addr = ATTR_BASE + {v[7:3],h[7:3]}, vram_rd=1.
  - RD_ATTR -> CAP_ATTR: E3 captures vram_q into pixel buffer; vram_rd=0.
  - CAP_ATTR -> IDLE: E4 captures vram_q into attribute buffer.
  - vram_rd is high exactly 2 clocks per group; never otherwise.
- Output latency 8 clocks: output at edge E8+k corresponds to input sampled at E0+k (k=0..7).
  - At E8, buffers load into the 8-bit shift register; MSB first.
  - The next group's fetch (E8..E12) overlaps without conflict.
- pix_active = busy delayed 8 clocks. Delay line also carries a "group loaded" flag.
- Colour when pix_active=1, with attr a and pixel bit b:
  - sel = b XOR (a[7] AND flash_phase)
  - pix_color = {a[6], sel ? a[2:0] : a[5:3]}
- pix_active=1 but no load yet this line (line started with p!=0): pix_color=0.
- pix_active=0: pix_color={1'b0, border delayed 8 clocks}.
- Flash counter increments once per frame, on the clock where busy falls (prev busy=1, busy=0) and the previous v_count=191. It wraps modulo 2^FLASH_BITS.
- busy deasserting mid-group: that group still fetches and emits its remaining pixels as pix_active=0, i.e. border colour. No partial-group output.

Test Plan:
- Addressing: busy=1, v_count=65, h_count=8..15 -> vram_addr=0x0901 with vram_rd=1 at E1, then 0x1901 at E2; vram_rd=0 at E3..E8.
- Serialisation: pixel byte 0xA5, attr 0x47 -> pix_color over 8 clocks from E8 = F,8,F,8,8,F,8,F; pix_active=1.
- Border/latency: busy=0, border=3'b101 -> pix_color=4'h5 exactly 8 clocks after border change; vram_rd stays 0.
- Flash: attr 0x87, pixel 0xFF, run 16 frames (v 191 busy falling edges) -> pix_color=7 in frames 0..15, 0 in frames 16..31, 7 again in frame 32.
- Full line: 256 active pixels -> exactly 32 groups, 64 vram_rd pulses; last pixel out 8 clocks after last input; no overrun of buffers.
- Reset mid-fetch: assert reset at E2 -> next clock vram_rd=0, pix_color=0, pix_active=0, flash counter 0; release and next phase-0 sample restarts a clean fetch.
